// File: rtl/colour_bbox_tracker_if.sv
// colour_bbox_tracker_if: Avalon-MM slave, Avalon-ST sink/source and mode bundle for colour_bbox_tracker
interface colour_bbox_tracker_if #(
    parameter int ADDR_W = 6
);
    logic              s_chipselect;
    logic              s_read;
    logic              s_write;
    logic [ADDR_W-1:0] s_address;
    logic [31:0]       s_writedata;
    logic [31:0]       s_readdata;
    logic [23:0]       sink_data;
    logic              sink_valid;
    logic              sink_sop;
    logic              sink_eop;
    logic              sink_ready;
    logic [23:0]       source_data;
    logic              source_valid;
    logic              source_sop;
    logic              source_eop;
    logic              source_ready;
    logic              mode;

    modport slave (
        input  s_chipselect, s_read, s_write, s_address, s_writedata,
        input  sink_data, sink_valid, sink_sop, sink_eop, source_ready, mode,
        output s_readdata, sink_ready, source_data, source_valid, source_sop, source_eop
    );

    modport master (
        output s_chipselect, s_read, s_write, s_address, s_writedata,
        output sink_data, sink_valid, sink_sop, sink_eop, source_ready, mode,
        input  s_readdata, sink_ready, source_data, source_valid, source_sop, source_eop
    );
endinterface

// File: rtl/colour_bbox_tracker.sv
// colour_bbox_tracker: per-colour RGB threshold bounding-box and pixel-count tracker
// sitting inline on an Avalon-ST video stream, results published over Avalon-MM.
module colour_bbox_tracker #(
    parameter int IMAGE_W     = 640,
    parameter int IMAGE_H     = 480,
    parameter int NUM_COLOURS = 4,
    parameter int ADDR_W      = 6
) (
    input logic                  clk,
    input logic                  reset,
    colour_bbox_tracker_if.slave bus
);
    localparam int CW = NUM_COLOURS > 1 ? $clog2(NUM_COLOURS) : 1;

    typedef enum logic [1:0] {S_HDR, S_VID, S_SKIP} pkt_t;
    pkt_t state, state_nx;

    logic [23:0] lo [NUM_COLOURS];
    logic [23:0] hi [NUM_COLOURS];
    logic [23:0] ovl [NUM_COLOURS];
    logic [NUM_COLOURS-1:0] en, found, hit;
    logic [15:0] acc_xmin [NUM_COLOURS], acc_xmax [NUM_COLOURS], acc_ymin [NUM_COLOURS], acc_ymax [NUM_COLOURS];
    logic [15:0] nx_xmin [NUM_COLOURS], nx_xmax [NUM_COLOURS], nx_ymin [NUM_COLOURS], nx_ymax [NUM_COLOURS];
    logic [15:0] res_xmin [NUM_COLOURS], res_xmax [NUM_COLOURS], res_ymin [NUM_COLOURS], res_ymax [NUM_COLOURS];
    logic [31:0] acc_cnt [NUM_COLOURS], nx_cnt [NUM_COLOURS], res_cnt [NUM_COLOURS];
    logic [CW-1:0] ch;
    logic [2:0] rsel;
    logic ch_ok, wr, accept, vid_sop, pixel, tracked, latch;
    logic [15:0] x, y;
    logic [23:0] pix_out;
    logic [31:0] rd;
    logic unused_wdata;

    assign ch           = bus.s_address[3 +: CW];
    assign rsel         = bus.s_address[2:0];
    assign ch_ok        = 32'(bus.s_address[ADDR_W-1:3]) < 32'(NUM_COLOURS);
    assign wr           = bus.s_chipselect && bus.s_write && ch_ok;
    assign unused_wdata = ^bus.s_writedata[31:24];

    assign bus.sink_ready = !bus.source_valid || bus.source_ready;
    assign accept         = bus.sink_valid && bus.sink_ready;
    assign vid_sop        = accept && bus.sink_sop && bus.sink_data[3:0] == 4'd0;
    assign pixel          = accept && !bus.sink_sop && state == S_VID;
    assign tracked        = pixel && y < 16'(IMAGE_H);
    assign latch          = pixel && bus.sink_eop;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_HDR;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (accept && bus.sink_sop)
            state_nx = bus.sink_eop ? S_HDR : bus.sink_data[3:0] == 4'd0 ? S_VID : S_SKIP;
        else if (accept && bus.sink_eop)
            state_nx = S_HDR;
    end

    // Walk channels high to low so the lowest-index match owns the overlay colour.
    always_comb begin
        hit = '0;
        pix_out = bus.sink_data;
        for (int i = NUM_COLOURS - 1; i >= 0; i--) begin
            hit[i] = tracked && en[i];
            for (int k = 0; k < 3; k++)
                if (bus.sink_data[8*k +: 8] < lo[i][8*k +: 8] || bus.sink_data[8*k +: 8] > hi[i][8*k +: 8])
                    hit[i] = 1'b0;
            nx_xmin[i] = hit[i] && x < acc_xmin[i] ? x : acc_xmin[i];
            nx_xmax[i] = hit[i] && x > acc_xmax[i] ? x : acc_xmax[i];
            nx_ymin[i] = hit[i] && y < acc_ymin[i] ? y : acc_ymin[i];
            nx_ymax[i] = hit[i] && y > acc_ymax[i] ? y : acc_ymax[i];
            nx_cnt[i]  = hit[i] && acc_cnt[i] != '1 ? acc_cnt[i] + 32'd1 : acc_cnt[i];
            if (hit[i] && bus.mode) pix_out = ovl[i];
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (vid_sop) begin
            x <= '0;
            y <= '0;
        end else if (pixel) begin
            x <= x == 16'(IMAGE_W - 1) ? '0 : x + 16'd1;
            if (x == 16'(IMAGE_W - 1) && y != 16'(IMAGE_H)) y <= y + 16'd1;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < NUM_COLOURS; i++) begin
                lo[i]  <= '1;
                hi[i]  <= '0;
                ovl[i] <= '0;
            end
            en <= '0;
        end else if (wr)
            case (rsel)
                3'd0: lo[ch] <= bus.s_writedata[23:0];
                3'd1: hi[ch] <= bus.s_writedata[23:0];
                3'd5: en[ch] <= bus.s_writedata[0];
                3'd6: ovl[ch] <= bus.s_writedata[23:0];
                default: ;
            endcase

    always_comb begin
        rd = '0;
        if (ch_ok)
            case (rsel)
                3'd0: rd = {8'd0, lo[ch]};
                3'd1: rd = {8'd0, hi[ch]};
                3'd2: rd = {res_xmax[ch], res_xmin[ch]};
                3'd3: rd = {res_ymax[ch], res_ymin[ch]};
                3'd4: rd = res_cnt[ch];
                3'd5: rd = {30'd0, found[ch], en[ch]};
                3'd6: rd = {8'd0, ovl[ch]};
                default: rd = '0;
            endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) bus.s_readdata <= '0;
        else if (bus.s_chipselect && bus.s_read) bus.s_readdata <= rd;

    // The eop pixel is folded in through nx_* before the copy to the result registers.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < NUM_COLOURS; i++) begin
                acc_xmin[i] <= '1;
                acc_ymin[i] <= '1;
                acc_xmax[i] <= '0;
                acc_ymax[i] <= '0;
                acc_cnt[i]  <= '0;
                res_xmin[i] <= '1;
                res_ymin[i] <= '1;
                res_xmax[i] <= '0;
                res_ymax[i] <= '0;
                res_cnt[i]  <= '0;
            end
            found <= '0;
        end else
            for (int i = 0; i < NUM_COLOURS; i++)
                if (latch) begin
                    res_xmin[i] <= nx_xmin[i];
                    res_xmax[i] <= nx_xmax[i];
                    res_ymin[i] <= nx_ymin[i];
                    res_ymax[i] <= nx_ymax[i];
                    res_cnt[i]  <= nx_cnt[i];
                    found[i]    <= nx_cnt[i] != 32'd0;
                    acc_xmin[i] <= '1;
                    acc_ymin[i] <= '1;
                    acc_xmax[i] <= '0;
                    acc_ymax[i] <= '0;
                    acc_cnt[i]  <= '0;
                end else begin
                    acc_xmin[i] <= nx_xmin[i];
                    acc_xmax[i] <= nx_xmax[i];
                    acc_ymin[i] <= nx_ymin[i];
                    acc_ymax[i] <= nx_ymax[i];
                    acc_cnt[i]  <= nx_cnt[i];
                end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.source_valid <= 1'b0;
            bus.source_data  <= '0;
            bus.source_sop   <= 1'b0;
            bus.source_eop   <= 1'b0;
        end else if (accept) begin
            bus.source_valid <= 1'b1;
            bus.source_data  <= pix_out;
            bus.source_sop   <= bus.sink_sop;
            bus.source_eop   <= bus.sink_eop;
        end else if (bus.source_ready)
            bus.source_valid <= 1'b0;
endmodule

// File: tb/tb_colour_bbox_tracker.sv
// tb_colour_bbox_tracker: table-driven register checks, directed frames and randomized
// frames checked against a frame-level reference model of the tracker.
module tb_colour_bbox_tracker;
    localparam int W = 4, H = 2, N = 4, AW = 6;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    colour_bbox_tracker_if #(.ADDR_W(AW)) bus ();
    colour_bbox_tracker #(.IMAGE_W(W), .IMAGE_H(H), .NUM_COLOURS(N), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    bit rand_bp = 0, force_low = 0, rnd_ready = 1;
    assign bus.source_ready = force_low ? 1'b0 : rand_bp ? rnd_ready : 1'b1;
    initial forever begin
        @(posedge clk);
        #1 rnd_ready = $urandom_range(0, 3) != 0;
    end

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: frame-level view using a linear pixel index.
    logic [23:0] m_lo [N], m_hi [N], m_ovl [N];
    bit m_en [N], r_found [N];
    logic [15:0] a_xmin [N], a_xmax [N], a_ymin [N], a_ymax [N];
    logic [15:0] r_xmin [N], r_xmax [N], r_ymin [N], r_ymax [N];
    logic [31:0] a_cnt [N], r_cnt [N];
    bit m_vid;
    int m_k;

    typedef struct {logic [23:0] d; logic sop; logic eop;} beat_t;
    beat_t exp_q [$];

    function automatic void clear_acc(int c);
        a_xmin[c] = 16'hFFFF; a_ymin[c] = 16'hFFFF; a_xmax[c] = 0; a_ymax[c] = 0; a_cnt[c] = 0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_lo[c] = 24'hFFFFFF; m_hi[c] = 0; m_ovl[c] = 0; m_en[c] = 0;
            clear_acc(c);
            r_xmin[c] = 16'hFFFF; r_ymin[c] = 16'hFFFF; r_xmax[c] = 0; r_ymax[c] = 0;
            r_cnt[c] = 0; r_found[c] = 0;
        end
        m_vid = 0;
        m_k = 0;
    endfunction

    function automatic void model_write(logic [5:0] a, logic [31:0] d);
        int c = int'(a[5:3]);
        if (c >= N) return;
        case (a[2:0])
            3'd0: m_lo[c] = d[23:0];
            3'd1: m_hi[c] = d[23:0];
            3'd5: m_en[c] = d[0];
            3'd6: m_ovl[c] = d[23:0];
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(logic [5:0] a);
        int c = int'(a[5:3]);
        if (c >= N) return 0;
        case (a[2:0])
            3'd0: return {8'd0, m_lo[c]};
            3'd1: return {8'd0, m_hi[c]};
            3'd2: return {r_xmax[c], r_xmin[c]};
            3'd3: return {r_ymax[c], r_ymin[c]};
            3'd4: return r_cnt[c];
            3'd5: return {30'd0, r_found[c], m_en[c]};
            3'd6: return {8'd0, m_ovl[c]};
            default: return 0;
        endcase
    endfunction

    function automatic bit in_win(logic [23:0] d, logic [23:0] l, logic [23:0] h);
        for (int k = 0; k < 3; k++)
            if (d[8*k +: 8] < l[8*k +: 8] || d[8*k +: 8] > h[8*k +: 8]) return 0;
        return 1;
    endfunction

    function automatic logic [23:0] model_accept(logic [23:0] d, logic sop, logic eop, logic md);
        logic [23:0] o;
        logic [15:0] x, y;
        bit taken;
        o = d;
        taken = 0;
        if (sop) begin
            if (d[3:0] == 4'd0) m_k = 0;
            m_vid = d[3:0] == 4'd0 && !eop;
        end else if (m_vid) begin
            x = 16'(m_k % W);
            y = 16'(m_k / W);
            if (m_k / W < H)
                for (int c = 0; c < N; c++)
                    if (m_en[c] && in_win(d, m_lo[c], m_hi[c])) begin
                        if (x < a_xmin[c]) a_xmin[c] = x;
                        if (x > a_xmax[c]) a_xmax[c] = x;
                        if (y < a_ymin[c]) a_ymin[c] = y;
                        if (y > a_ymax[c]) a_ymax[c] = y;
                        if (a_cnt[c] != 32'hFFFFFFFF) a_cnt[c]++;
                        if (md && !taken) begin
                            o = m_ovl[c];
                            taken = 1;
                        end
                    end
            m_k++;
            if (eop) begin
                for (int c = 0; c < N; c++) begin
                    r_xmin[c] = a_xmin[c]; r_xmax[c] = a_xmax[c];
                    r_ymin[c] = a_ymin[c]; r_ymax[c] = a_ymax[c];
                    r_cnt[c] = a_cnt[c]; r_found[c] = a_cnt[c] != 0;
                    clear_acc(c);
                end
                m_vid = 0;
            end
        end
        return o;
    endfunction

    // Output monitor: ordering against the expected queue and stability while stalled.
    logic [23:0] hold_d;
    bit hold = 0;
    always @(negedge clk) begin
        beat_t e;
        if (reset) hold = 0;
        else begin
            if (hold && bus.source_valid) chk("stall_hold", {8'd0, bus.source_data}, {8'd0, hold_d});
            if (bus.source_valid && bus.source_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", {8'd0, bus.source_data}, 32'hFFFFFFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("out_beat", {6'd0, bus.source_sop, bus.source_eop, bus.source_data}, {6'd0, e.sop, e.eop, e.d});
                end
                hold = 0;
            end else if (bus.source_valid) begin
                hold = 1;
                hold_d = bus.source_data;
            end else hold = 0;
        end
    end

    task automatic mm_write(input logic [5:0] a, input logic [31:0] d);
        bus.s_chipselect = 1; bus.s_write = 1; bus.s_address = a; bus.s_writedata = d;
        @(posedge clk);
        #1 bus.s_chipselect = 0; bus.s_write = 0;
        model_write(a, d);
    endtask

    task automatic mm_read(input logic [5:0] a, output logic [31:0] d);
        bus.s_chipselect = 1; bus.s_read = 1; bus.s_address = a;
        @(posedge clk);
        #1 bus.s_chipselect = 0; bus.s_read = 0;
        d = bus.s_readdata;
    endtask

    task automatic check_regs(input int c);
        logic [31:0] d;
        for (int r = 0; r < 8; r++) begin
            mm_read(6'(c * 8 + r), d);
            chk($sformatf("reg_c%0d_r%0d", c, r), d, model_read(6'(c * 8 + r)));
        end
    endtask

    task automatic check_const(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        mm_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop);
        logic [23:0] e;
        int n = 0;
        bus.sink_data = d; bus.sink_sop = sop; bus.sink_eop = eop; bus.sink_valid = 1;
        @(negedge clk);
        while (!bus.sink_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.sink_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: sink_ready stayed 0 for %0d cycles, required 1", n);
            bus.sink_valid = 0;
            return;
        end
        e = model_accept(d, sop, eop, bus.mode);
        exp_q.push_back('{e, sop, eop});
        @(posedge clk);
        #1 bus.sink_valid = 0;
        chk("latency", {7'd0, bus.source_valid, bus.source_data}, {7'd0, 1'b1, e});
    endtask

    task automatic send_frame(input logic [23:0] px [$]);
        send_beat(24'h0, 1, 0);
        foreach (px[i]) send_beat(px[i], 0, i == px.size() - 1);
    endtask

    task automatic do_reset();
        reset = 1;
        bus.sink_valid = 0; bus.s_chipselect = 0; bus.s_read = 0; bus.s_write = 0;
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1 chk("rst_outputs", {5'd0, bus.source_valid, bus.source_sop, bus.source_eop, bus.source_data}, 0);
        chk("rst_readdata", bus.s_readdata, 0);
        reset = 0;
    endtask

    typedef struct {bit wr; logic [5:0] addr; logic [31:0] data; logic [31:0] exp;} mm_vec_t;
    mm_vec_t vt [19];

    initial begin
        logic [23:0] px [$];
        logic [31:0] d;
        int n;
        vt[0]  = '{0, 6'd0,  32'h0,        32'h00FFFFFF};
        vt[1]  = '{0, 6'd1,  32'h0,        32'h00000000};
        vt[2]  = '{0, 6'd2,  32'h0,        32'h0000FFFF};
        vt[3]  = '{0, 6'd3,  32'h0,        32'h0000FFFF};
        vt[4]  = '{0, 6'd4,  32'h0,        32'h00000000};
        vt[5]  = '{0, 6'd5,  32'h0,        32'h00000000};
        vt[6]  = '{0, 6'd6,  32'h0,        32'h00000000};
        vt[7]  = '{0, 6'd7,  32'h0,        32'h00000000};
        vt[8]  = '{1, 6'd8,  32'h12ABCDEF, 32'h0};
        vt[9]  = '{0, 6'd8,  32'h0,        32'h00ABCDEF};
        vt[10] = '{1, 6'd13, 32'hFFFFFFFF, 32'h0};
        vt[11] = '{0, 6'd13, 32'h0,        32'h00000001};
        vt[12] = '{1, 6'd32, 32'h00000123, 32'h0};
        vt[13] = '{0, 6'd32, 32'h0,        32'h00000000};
        vt[14] = '{0, 6'd63, 32'h0,        32'h00000000};
        vt[15] = '{1, 6'd14, 32'h00AABBCC, 32'h0};
        vt[16] = '{0, 6'd14, 32'h0,        32'h00AABBCC};
        vt[17] = '{0, 6'd15, 32'h0,        32'h00000000};
        vt[18] = '{0, 6'd9,  32'h0,        32'h00000000};

        bus.s_chipselect = 0; bus.s_read = 0; bus.s_write = 0; bus.s_address = 0; bus.s_writedata = 0;
        bus.sink_data = 0; bus.sink_valid = 0; bus.sink_sop = 0; bus.sink_eop = 0; bus.mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 do_reset();

        foreach (vt[i]) begin
            if (vt[i].wr) mm_write(vt[i].addr, vt[i].data);
            else begin
                mm_read(vt[i].addr, d);
                chk($sformatf("table_%0d", i), d, vt[i].exp);
            end
        end

        // Read and write on the same edge: read sees the pre-write value.
        bus.s_chipselect = 1; bus.s_read = 1; bus.s_write = 1; bus.s_address = 6'd8; bus.s_writedata = 32'h00111111;
        @(posedge clk);
        #1 bus.s_chipselect = 0; bus.s_read = 0; bus.s_write = 0;
        chk("rw_same_cycle", bus.s_readdata, 32'h00ABCDEF);
        model_write(6'd8, 32'h00111111);
        check_const("rw_after", 6'd8, 32'h00111111);
        do_reset();

        // Directed 4x2 frame with two red pixels.
        mm_write(6'd0, 32'h00800000);
        mm_write(6'd1, 32'h00FF3030);
        mm_write(6'd5, 32'h1);
        mm_write(6'd6, 32'h0000FF00);
        px = '{24'h0, 24'hC01010, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hC01010};
        send_frame(px);
        check_const("f1_xbox", 6'd2, 32'h00030001);
        check_const("f1_ybox", 6'd3, 32'h00010000);
        check_const("f1_count", 6'd4, 32'd2);
        check_const("f1_ctrl", 6'd5, 32'd3);
        check_regs(0);

        bus.mode = 1;
        send_frame(px);
        check_const("f2_count", 6'd4, 32'd2);

        // Backpressure mid-frame: source_ready low for 3 cycles.
        bus.mode = 0;
        send_beat(24'h0, 1, 0);
        for (int i = 0; i < 3; i++) send_beat(px[i], 0, 0);
        force_low = 1;
        bus.sink_data = px[3]; bus.sink_sop = 0; bus.sink_eop = 0; bus.sink_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_sink_ready", {31'd0, bus.sink_ready}, 0);
        end
        @(posedge clk);
        #1 force_low = 0;
        for (int i = 3; i < 8; i++) send_beat(px[i], 0, i == 7);
        check_regs(0);

        // Non-video packet with red pixels: forwarded untouched, results unchanged.
        bus.mode = 1;
        send_beat(24'h00000F, 1, 0);
        send_beat(24'hC01010, 0, 0);
        send_beat(24'hC01010, 0, 1);
        check_const("nonvid_count", 6'd4, 32'd2);
        check_regs(0);

        // Overlapping windows, reset mid-frame, then a full frame.
        mm_write(6'd8, 32'h00400000);
        mm_write(6'd9, 32'h00FFFFFF);
        mm_write(6'd13, 32'h1);
        mm_write(6'd14, 32'h000000FF);
        send_beat(24'h0, 1, 0);
        send_beat(24'hC01010, 0, 0);
        send_beat(24'h500000, 0, 0);
        do_reset();
        mm_write(6'd0, 32'h00800000);
        mm_write(6'd1, 32'h00FF3030);
        mm_write(6'd5, 32'h1);
        mm_write(6'd6, 32'h0000FF00);
        mm_write(6'd8, 32'h00400000);
        mm_write(6'd9, 32'h00FFFFFF);
        mm_write(6'd13, 32'h1);
        mm_write(6'd14, 32'h000000FF);
        bus.mode = 1;
        px = '{24'h0, 24'hC01010, 24'h500000, 24'h0, 24'h0, 24'h500000, 24'hC01010, 24'h0};
        send_beat(24'h0, 1, 0);
        for (int i = 0; i < 7; i++) send_beat(px[i], 0, 0);
        bus.s_chipselect = 1; bus.s_read = 1; bus.s_address = 6'd4;
        send_beat(px[7], 0, 1);
        bus.s_chipselect = 0; bus.s_read = 0;
        chk("eop_edge_read", bus.s_readdata, 32'd0);
        check_const("ovl_c0_count", 6'd4, 32'd2);
        check_const("ovl_c0_xbox", 6'd2, 32'h00020001);
        check_const("ovl_c1_count", 6'd12, 32'd4);
        check_regs(0);
        check_regs(1);

        // Randomized frames with random backpressure.
        rand_bp = 1;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < N; c++) begin
                mm_write(6'(c * 8), {8'd0, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127))});
                mm_write(6'(c * 8 + 1), {8'd0, 8'($urandom_range(128, 255)), 8'($urandom_range(128, 255)), 8'($urandom_range(128, 255))});
                mm_write(6'(c * 8 + 5), {31'd0, 1'($urandom_range(0, 3) != 0)});
                mm_write(6'(c * 8 + 6), {8'd0, 24'($urandom)});
            end
            bus.mode = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: begin
                    send_beat(24'h000003, 1, 0);
                    send_beat(24'($urandom), 0, 0);
                    send_beat(24'($urandom), 0, 1);
                end
                1: begin
                    send_beat(24'h0, 1, 0);
                    send_beat(24'($urandom), 0, 0);
                    send_beat(24'($urandom), 0, 0);
                end
                default: ;
            endcase
            n = $urandom_range(1, 11);
            px.delete();
            for (int i = 0; i < n; i++) px.push_back(24'($urandom));
            send_frame(px);
            for (int c = 0; c < N; c++) check_regs(c);
        end
        rand_bp = 0;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
